// File: rtl/axis_adc_decimator_if.sv
// AXI-Stream bundle (tdata/tvalid/tready) shared by the decimator's
// sample input and its sum output.
interface axis_adc_decimator_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;

   modport master (
      output tdata,
      output tvalid,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      output tready
   );
endinterface

// File: rtl/axis_adc_decimator.sv
// Boxcar decimator: sums N consecutive complex ADC samples per component
// and hands each sum to a single-entry, back-pressurable AXI-Stream output.
// Sums that complete while the output is still occupied are dropped and
// counted in the overrun status.
module axis_adc_decimator #(
   parameter int S_AXIS_TDATA_WIDTH = 32,
   parameter int CNTR_WIDTH         = 16,
   parameter int M_AXIS_TDATA_WIDTH = 64
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   axis_adc_decimator_if.slave   s_axis,
   axis_adc_decimator_if.master  m_axis,
   input  logic [CNTR_WIDTH-1:0] cfg_rate,
   input  logic                  enable,
   input  logic                  ovr_clr,
   output logic                  sts_overrun,
   output logic [15:0]           sts_drops
);
   localparam int IW = S_AXIS_TDATA_WIDTH / 2;
   localparam int OW = M_AXIS_TDATA_WIDTH / 2;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

   // The output components must hold N full-scale inputs without overflow.
   generate
      if (M_AXIS_TDATA_WIDTH < S_AXIS_TDATA_WIDTH + 2 * CNTR_WIDTH) begin : g_width_check
         $error("axis_adc_decimator: M_AXIS_TDATA_WIDTH must be >= S_AXIS_TDATA_WIDTH + 2*CNTR_WIDTH");
      end
   endgenerate

   logic [0:0]              state;
   logic [CNTR_WIDTH-1:0]   cnt;
   logic [CNTR_WIDTH-1:0]   last_idx;
   logic [CNTR_WIDTH-1:0]   rate_eff;
   logic [CNTR_WIDTH-1:0]   blk_last;
   logic signed [OW-1:0]    acc_re;
   logic signed [OW-1:0]    acc_im;
   logic signed [OW-1:0]    samp_re;
   logic signed [OW-1:0]    samp_im;
   logic signed [OW-1:0]    sum_re;
   logic signed [OW-1:0]    sum_im;
   logic                    accept;
   logic                    complete;
   logic                    fire;
   logic                    load;
   logic                    drop;
   logic                    out_valid;
   logic [M_AXIS_TDATA_WIDTH-1:0] out_data;

   // The ADC stage cannot be stalled, so the input is always ready.
   assign s_axis.tready = 1'b1;
   assign m_axis.tvalid = out_valid;
   assign m_axis.tdata  = out_data;

   // A rate of 0 behaves as 1; the rate only matters at block start, after
   // which the latched last index governs the rest of the block.
   assign rate_eff = (cfg_rate == '0) ? CNT_ONE : cfg_rate;
   assign blk_last = (cnt == '0) ? (rate_eff - CNT_ONE) : last_idx;

   assign samp_re = {{(OW - IW){s_axis.tdata[IW-1]}}, s_axis.tdata[IW-1:0]};
   assign samp_im = {{(OW - IW){s_axis.tdata[2*IW-1]}}, s_axis.tdata[2*IW-1:IW]};
   assign sum_re  = (cnt == '0) ? samp_re : (acc_re + samp_re);
   assign sum_im  = (cnt == '0) ? samp_im : (acc_im + samp_im);

   assign accept   = (state == RUN) && enable && s_axis.tvalid;
   assign complete = accept && (cnt == blk_last);
   assign fire     = out_valid && m_axis.tready;
   assign load     = complete && (!out_valid || m_axis.tready);
   assign drop     = complete && !load;

   // Run/idle state, block counter, rate latch and accumulators.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state    <= IDLE;
         cnt      <= '0;
         last_idx <= '0;
         acc_re   <= '0;
         acc_im   <= '0;
      end else if (!enable) begin
         state  <= IDLE;
         cnt    <= '0;
         acc_re <= '0;
         acc_im <= '0;
      end else begin
         state <= RUN;
         if (accept) begin
            if (cnt == '0) begin
               last_idx <= rate_eff - CNT_ONE;
            end
            if (complete) begin
               cnt <= '0;
            end else begin
               cnt <= cnt + CNT_ONE;
            end
            acc_re <= sum_re;
            acc_im <= sum_im;
         end
      end
   end

   // Single-entry output holding register; a new sum may replace a beat
   // that is leaving in the same cycle.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= {sum_im, sum_re};
      end else if (fire) begin
         out_valid <= 1'b0;
      end
   end

   // Sticky overrun flag and saturating drop counter; a drop beats a clear.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         sts_overrun <= 1'b0;
         sts_drops   <= '0;
      end else if (drop) begin
         sts_overrun <= 1'b1;
         if (ovr_clr) begin
            sts_drops <= 16'd1;
         end else if (sts_drops != 16'hFFFF) begin
            sts_drops <= sts_drops + 16'd1;
         end
      end else if (ovr_clr) begin
         sts_overrun <= 1'b0;
         sts_drops   <= '0;
      end
   end
endmodule

// File: tb/tb_axis_adc_decimator.sv
// Self-checking bench for axis_adc_decimator: directed scenarios with
// literal expectations, then randomized traffic against a queue-based model.
module tb_axis_adc_decimator;
   logic        aclk = 1'b0;
   logic        aresetn;
   logic [15:0] cfg_rate;
   logic        enable;
   logic        ovr_clr;
   logic        sts_overrun;
   logic [15:0] sts_drops;

   int checks = 0;
   int errors = 0;
   bit checkEn = 1'b0;

   logic [63:0] beats[$];

   // Reference model state
   bit          mRun = 1'b0;
   int          blkN = 1;
   longint      qRe[$];
   longint      qIm[$];
   logic        mPend = 1'b0;
   logic [63:0] mData = '0;
   logic        mOvr = 1'b0;
   logic [15:0] mDrops = '0;

   axis_adc_decimator_if #(.DATA_WIDTH(32)) s_axis();
   axis_adc_decimator_if #(.DATA_WIDTH(64)) m_axis();

   axis_adc_decimator #(
      .S_AXIS_TDATA_WIDTH(32),
      .CNTR_WIDTH(16),
      .M_AXIS_TDATA_WIDTH(64)
   ) dut (
      .aclk(aclk),
      .aresetn(aresetn),
      .s_axis(s_axis),
      .m_axis(m_axis),
      .cfg_rate(cfg_rate),
      .enable(enable),
      .ovr_clr(ovr_clr),
      .sts_overrun(sts_overrun),
      .sts_drops(sts_drops)
   );

   // Free-running 100 MHz clock.
   always #5 aclk = ~aclk;

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic checkBeat(input string name, input logic [63:0] exp);
      if (beats.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: no beat delivered, expected %h", name, exp);
      end else begin
         checkOutput(name, beats.pop_front(), exp);
      end
   endtask

   // Advance the model by one edge using the inputs present at that edge:
   // samples are collected per block and summed once the block is full.
   task automatic modelStep();
      logic        haveRes;
      logic        fire;
      logic        loaded;
      logic [63:0] res;
      longint      sr;
      longint      si;
      haveRes = 1'b0;
      loaded  = 1'b0;
      res     = '0;
      if (!aresetn) begin
         mRun   = 1'b0;
         qRe.delete();
         qIm.delete();
         mPend  = 1'b0;
         mData  = '0;
         mOvr   = 1'b0;
         mDrops = '0;
      end else begin
         fire = mPend && m_axis.tready;
         if (mRun && enable && s_axis.tvalid) begin
            if (qRe.size() == 0) blkN = (cfg_rate == 16'd0) ? 1 : int'(cfg_rate);
            qRe.push_back(longint'($signed(s_axis.tdata[15:0])));
            qIm.push_back(longint'($signed(s_axis.tdata[31:16])));
            if (qRe.size() == blkN) begin
               sr = 0;
               si = 0;
               foreach (qRe[i]) begin
                  sr += qRe[i];
                  si += qIm[i];
               end
               res     = {si[31:0], sr[31:0]};
               haveRes = 1'b1;
               qRe.delete();
               qIm.delete();
            end
         end
         if (!enable) begin
            qRe.delete();
            qIm.delete();
         end
         mRun = enable;
         if (haveRes && (!mPend || fire)) begin
            mPend  = 1'b1;
            mData  = res;
            loaded = 1'b1;
         end else if (fire) begin
            mPend = 1'b0;
         end
         if (haveRes && !loaded) begin
            mOvr   = 1'b1;
            mDrops = ovr_clr ? 16'd1 : ((mDrops == 16'hFFFF) ? mDrops : mDrops + 16'd1);
         end else if (ovr_clr) begin
            mOvr   = 1'b0;
            mDrops = '0;
         end
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, then update the model.
   task automatic applyStimulus(input logic rstn, input logic en, input logic tv,
                                input logic [31:0] data, input logic rdy, input logic clr);
      aresetn       = rstn;
      enable        = en;
      s_axis.tvalid = tv;
      s_axis.tdata  = data;
      m_axis.tready = rdy;
      ovr_clr       = clr;
      @(posedge aclk);
      modelStep();
      #1;
   endtask

   task automatic sample(input logic [31:0] data, input logic rdy);
      applyStimulus(1'b1, 1'b1, 1'b1, data, rdy, 1'b0);
   endtask

   // Compare DUT outputs against the model away from the active edge.
   always @(negedge aclk) begin
      if (checkEn) begin
         checkOutput("tvalid", 64'(m_axis.tvalid), 64'(mPend));
         if (mPend) checkOutput("tdata", m_axis.tdata, mData);
         checkOutput("overrun", 64'(sts_overrun), 64'(mOvr));
         checkOutput("drops", 64'(sts_drops), 64'(mDrops));
         checkOutput("s_tready", 64'(s_axis.tready), 64'd1);
         if (m_axis.tvalid && m_axis.tready) beats.push_back(m_axis.tdata);
      end
   end

   // Directed scenarios followed by randomized traffic.
   initial begin
      cfg_rate = 16'd4;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      checkEn = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      checkOutput("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
      checkOutput("rst_tdata", m_axis.tdata, 64'd0);
      checkOutput("rst_overrun", 64'(sts_overrun), 64'd0);
      checkOutput("rst_drops", 64'(sts_drops), 64'd0);

      $display("[TB] N=4 ramp");
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         sample(32'(i), 1'b1);
         if (i == 3) checkOutput("n4_early", 64'(m_axis.tvalid), 64'd0);
      end
      checkOutput("n4_tvalid", 64'(m_axis.tvalid), 64'd1);
      checkOutput("n4_tdata", m_axis.tdata, 64'd10);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      checkOutput("n4_onecycle", 64'(m_axis.tvalid), 64'd0);
      checkBeat("n4_beat", 64'd10);

      $display("[TB] N=3 negative");
      cfg_rate = 16'd3;
      for (int i = 0; i < 3; i++) sample(32'h0005_FF9C, 1'b1);
      checkOutput("n3_tdata", m_axis.tdata, 64'h0000000F_FFFFFED4);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      checkBeat("n3_beat", 64'h0000000F_FFFFFED4);

      $display("[TB] N=2 overrun");
      cfg_rate = 16'd2;
      sample(32'd1, 1'b0);
      sample(32'd1, 1'b0);
      checkOutput("ovr_first", m_axis.tdata, 64'd2);
      sample(32'd1, 1'b0);
      sample(32'd1, 1'b0);
      checkOutput("ovr_held", m_axis.tdata, 64'd2);
      checkOutput("ovr_flag", 64'(sts_overrun), 64'd1);
      checkOutput("ovr_drops", 64'(sts_drops), 64'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      checkOutput("ovr_drained", 64'(m_axis.tvalid), 64'd0);
      checkBeat("ovr_beat", 64'd2);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
      checkOutput("clr_flag", 64'(sts_overrun), 64'd0);
      checkOutput("clr_drops", 64'(sts_drops), 64'd0);

      $display("[TB] N=2 back-to-back");
      sample(32'd3, 1'b0);
      sample(32'd3, 1'b0);
      sample(32'd5, 1'b0);
      sample(32'd5, 1'b1);
      checkOutput("b2b_tdata", m_axis.tdata, 64'd10);
      checkOutput("b2b_overrun", 64'(sts_overrun), 64'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      checkBeat("b2b_beat0", 64'd6);
      checkBeat("b2b_beat1", 64'd10);

      $display("[TB] N=8 with enable gap");
      cfg_rate = 16'd8;
      for (int i = 0; i < 3; i++) sample(32'd7, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'd100, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'd100, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'd100, 1'b1, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         sample(32'd1, 1'b1);
         if (i == 7) checkOutput("gap_early", 64'(m_axis.tvalid), 64'd0);
      end
      checkOutput("gap_tdata", m_axis.tdata, 64'd8);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      checkBeat("gap_beat", 64'd8);

      $display("[TB] rate 0 pass-through");
      cfg_rate = 16'd0;
      sample(32'h8000_8000, 1'b1);
      checkOutput("pt_min", m_axis.tdata, 64'hFFFF8000_FFFF8000);
      sample(32'h0001_7FFF, 1'b1);
      checkOutput("pt_next", m_axis.tdata, 64'h00000001_00007FFF);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      checkBeat("pt_beat0", 64'hFFFF8000_FFFF8000);
      checkBeat("pt_beat1", 64'h00000001_00007FFF);

      $display("[TB] reset mid-block");
      cfg_rate = 16'd4;
      for (int i = 0; i < 6; i++) sample(32'd2, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'd2, 1'b0, 1'b0);
      checkOutput("mrst_tvalid", 64'(m_axis.tvalid), 64'd0);
      checkOutput("mrst_tdata", m_axis.tdata, 64'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      sample(32'd2, 1'b1);
      sample(32'd2, 1'b1);
      checkOutput("mrst_nostale", 64'(m_axis.tvalid), 64'd0);
      sample(32'd2, 1'b1);
      sample(32'd2, 1'b1);
      checkOutput("mrst_fresh", m_axis.tdata, 64'd8);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);

      $display("[TB] randomized traffic");
      begin
         int rdyBias;
         rdyBias = 3;
         for (int c = 0; c < 4000; c++) begin
            if (c % 150 == 0) begin
               cfg_rate = 16'($urandom_range(0, 5));
               rdyBias  = $urandom_range(0, 4);
            end
            applyStimulus($urandom_range(0, 299) != 0,
                          $urandom_range(0, 19) != 0,
                          $urandom_range(0, 7) != 0,
                          32'($urandom),
                          $urandom_range(0, 3) < rdyBias,
                          $urandom_range(0, 49) == 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
